// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: {bout,d} = a - b - bin, DIGIT_W bits per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int N       = 16,
  parameter int DIGIT_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int NUM_DIGITS = N / DIGIT_W;
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

  generate
    if (N % DIGIT_W != 0) begin : g_bad_digit_w
      $error("serial_subtractor: DIGIT_W must divide N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     a_sh, b_sh, d_sh, d_sh_nxt;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [DIGIT_W:0] dig;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  // Top bit of the DIGIT_W+1-bit difference is the borrow into the next digit.
  assign dig      = {1'b0, a_sh[DIGIT_W-1:0]} - {1'b0, b_sh[DIGIT_W-1:0]} - (DIGIT_W+1)'(borrow);
  assign d_sh_nxt = (d_sh >> DIGIT_W) | (N'(dig[DIGIT_W-1:0]) << (N - DIGIT_W));
  assign last     = (cnt == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working shift registers are separate from d so the visible result only
  // changes when a new one completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b;
          borrow <= bin;
          cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb  <= a[N-1];
          b_msb  <= b[N-1];
`endif
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          d_sh   <= d_sh_nxt;
          borrow <= dig[DIGIT_W];
          cnt    <= cnt + 1'b1;
          if (last) begin
            d    <= d_sh_nxt;
            bout <= dig[DIGIT_W];
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) & (d_sh_nxt[N-1] != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: N=16/DIGIT_W=1 and N=8/DIGIT_W=4 instances.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v16 = 1'b0, rdy16, ov16, ordy16 = 1'b1, bin16 = 1'b0, bout16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, d16;
  logic        v8 = 1'b0, rdy8, ov8, ordy8 = 1'b1, bin8 = 1'b0, bout8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0, d8;

  serial_subtractor #(.N(16), .DIGIT_W(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(ordy16), .d(d16), .bout(bout16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  serial_subtractor #(.N(8), .DIGIT_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(ordy8), .d(d8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf16 = 1'b0;
  assign ovf8  = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      output logic [15:0] d, output logic bo, output logic ov, output int lat);
    int w = 0;
    while (!rdy16 && w < 100) begin tick(); w++; end
    chk("rdy16_wait", 32'(rdy16), 32'd1);
    a16 = a; b16 = b; bin16 = bin; v16 = 1'b1;
    tick();
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    lat = 0;
    while (!ov16 && lat < 100) begin tick(); lat++; end
    d = d16; bo = bout16; ov = ovf16;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output logic [7:0] d, output logic bo, output int lat);
    int w = 0;
    while (!rdy8 && w < 100) begin tick(); w++; end
    chk("rdy8_wait", 32'(rdy8), 32'd1);
    a8 = a; b8 = b; bin8 = bin; v8 = 1'b1;
    tick();
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin tick(); lat++; end
    d = d8; bo = bout8;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        bo, ov;
    int          lat;
    logic [7:0]  d_8;
    logic [8:0]  e9;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(rdy16), 32'd1);
    chk("rst_out_valid", 32'(ov16), 32'd0);
    chk("rst_d", 32'(d16), 32'd0);
    chk("rst_bout", 32'(bout16), 32'd0);
    chk("rst_ovf", 32'(ovf16), 32'd0);
    chk("rst8_in_ready", 32'(rdy8), 32'd1);

    // Case 1: 5 - 3
    op16(16'd5, 16'd3, 1'b0, d, bo, ov, lat);
    chk("c1_lat", 32'(lat), 32'd16);
    chk("c1_d", 32'(d), 32'd2);
    chk("c1_bout", 32'(bo), 32'd0);

    // Case 2: wrap cases
    op16(16'd0, 16'd1, 1'b0, d, bo, ov, lat);
    chk("c2a_d", 32'(d), 32'hFFFF);
    chk("c2a_bout", 32'(bo), 32'd1);
    op16(16'd0, 16'hFFFF, 1'b1, d, bo, ov, lat);
    chk("c2b_d", 32'(d), 32'd0);
    chk("c2b_bout", 32'(bo), 32'd1);

    // Boundaries and a mixed pattern
    op16(16'h1234, 16'h1234, 1'b0, d, bo, ov, lat);
    chk("eq_d", 32'(d), 32'd0);
    chk("eq_bout", 32'(bo), 32'd0);
    op16(16'd0, 16'd0, 1'b1, d, bo, ov, lat);
    chk("binonly_d", 32'(d), 32'hFFFF);
    chk("binonly_bout", 32'(bo), 32'd1);
    op16(16'hABCD, 16'h1234, 1'b1, d, bo, ov, lat);
    chk("mix_d", 32'(d), 32'h9998);
    chk("mix_bout", 32'(bo), 32'd0);
    repeat (4) tick();
    chk("idle_hold_d", 32'(d16), 32'h9998);
    chk("idle_ready", 32'(rdy16), 32'd1);

    // Case 3: backpressure for 10 cycles with ignored in_valid pulses
    ordy16 = 1'b0;
    op16(16'd100, 16'd7, 1'b0, d, bo, ov, lat);
    chk("c3_lat", 32'(lat), 32'd16);
    chk("c3_d", 32'(d), 32'd93);
    for (int i = 0; i < 10; i++) begin
      v16 = 1'b1; a16 = 16'h5555; b16 = 16'h0101;
      tick();
      chk("c3_hold_d", 32'(d16), 32'd93);
      chk("c3_hold_bout", 32'(bout16), 32'd0);
      chk("c3_hold_in_ready", 32'(rdy16), 32'd0);
      chk("c3_hold_out_valid", 32'(ov16), 32'd1);
    end
    v16 = 1'b0;
    ordy16 = 1'b1;
    tick();
    chk("c3_release_out_valid", 32'(ov16), 32'd0);
    chk("c3_release_in_ready", 32'(rdy16), 32'd1);
    chk("c3_keep_d", 32'(d16), 32'd93);
    tick();
    chk("c3_no_second_accept", 32'(rdy16), 32'd1);

    // Case 4: reset mid-RUN
    a16 = 16'd1000; b16 = 16'd1; bin16 = 1'b0; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    repeat (7) tick();
    chk("c4_running", 32'(rdy16), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c4_in_ready", 32'(rdy16), 32'd1);
    chk("c4_out_valid", 32'(ov16), 32'd0);
    chk("c4_d", 32'(d16), 32'd0);
    chk("c4_bout", 32'(bout16), 32'd0);
    op16(16'd100, 16'd40, 1'b0, d, bo, ov, lat);
    chk("c4_next_d", 32'(d), 32'd60);
    chk("c4_next_lat", 32'(lat), 32'd16);

    // Case 5: N=8, DIGIT_W=4 sampled sweep including 0 and 255
    for (int ia = 0; ia <= 255; ia += 17) begin
      for (int ib = 0; ib <= 255; ib += 15) begin
        for (int ic = 0; ic < 2; ic++) begin
          e9 = {1'b0, 8'(ia)} - {1'b0, 8'(ib)} - 9'(ic);
          op8(8'(ia), 8'(ib), 1'(ic), d_8, bo, lat);
          chk("c5_d", 32'(d_8), 32'(e9[7:0]));
          chk("c5_bout", 32'(bo), 32'(e9[8]));
          chk("c5_lat", 32'(lat), 32'd2);
        end
      end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Case 6: signed overflow flag
    op16(16'h8000, 16'd1, 1'b0, d, bo, ov, lat);
    chk("c6a_d", 32'(d), 32'h7FFF);
    chk("c6a_ovf", 32'(ov), 32'd1);
    op16(16'h7FFF, 16'hFFFF, 1'b0, d, bo, ov, lat);
    chk("c6b_d", 32'(d), 32'h8000);
    chk("c6b_ovf", 32'(ov), 32'd1);
    op16(16'd5, 16'd3, 1'b0, d, bo, ov, lat);
    chk("c6c_d", 32'(d), 32'd2);
    chk("c6c_ovf", 32'(ov), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
